// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates I/D cache requests (D priority, I anti-starvation),
// runs one RAM transaction per grant and answers with a single-cycle wait-low response.
module mem_responder #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RESP} state_t;

   localparam logic [1:0] RS_ACCESS = 2'b10;
   localparam logic [1:0] RS_ERROR  = 2'b11;
   localparam logic [7:0] TO_CNT    = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        srv_d_q, srv_d_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  dstreak_q, dstreak_d;
   logic        err_q, err_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         srv_d_q   <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         dstreak_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         srv_d_q   <= srv_d_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         dstreak_q <= dstreak_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      srv_d_d   = srv_d_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      dstreak_d = dstreak_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            // D wins unless I has already waited through two consecutive D grants
            if ((dREN || dWEN) && (!iREN || dstreak_q < 2'd2)) begin
               state_d   = D_ACC;
               addr_d    = daddr;
               wdata_d   = dstore;
               we_d      = dWEN;
               srv_d_d   = 1'b1;
               cnt_d     = '0;
               dstreak_d = !iREN ? 2'd0 : (dstreak_q == 2'd2) ? 2'd2 : dstreak_q + 2'd1;
            end else if (iREN) begin
               state_d   = I_ACC;
               addr_d    = iaddr;
               wdata_d   = '0;
               we_d      = 1'b0;
               srv_d_d   = 1'b0;
               cnt_d     = '0;
               dstreak_d = 2'd0;
            end
         end
         D_ACC, I_ACC: begin
            if (ramstate == RS_ACCESS) begin
               rdata_d = ramload;
               state_d = RESP;
            end else if (ramstate == RS_ERROR || cnt_q == TO_CNT) begin
               rdata_d = ERR_WORD;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      case (state_q)
         D_ACC: begin
            ramREN   = !we_q;
            ramWEN   = we_q;
            ramaddr  = addr_q;
            ramstore = wdata_q;
         end
         I_ACC: begin
            ramREN   = 1'b1;
            ramaddr  = addr_q;
            ramstore = wdata_q;
         end
         RESP: begin
            if (srv_d_q) begin
               dwait = 1'b0;
               dload = rdata_q;
            end else begin
               iwait = 1'b0;
               iload = rdata_q;
            end
         end
         default: ;
      endcase
      err = err_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN, err;

   int checks   = 0;
   int failures = 0;

   localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;

   mem_responder #(.TIMEOUT(4), .ERR_WORD(32'hBAD1BAD1)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_iwait"},    32'(iwait),    32'd1);
      chk({tag, "_dwait"},    32'(dwait),    32'd1);
      chk({tag, "_iload"},    iload,         32'd0);
      chk({tag, "_dload"},    dload,         32'd0);
      chk({tag, "_ramREN"},   32'(ramREN),   32'd0);
      chk({tag, "_ramWEN"},   32'(ramWEN),   32'd0);
      chk({tag, "_ramaddr"},  ramaddr,       32'd0);
      chk({tag, "_ramstore"}, ramstore,      32'd0);
      chk({tag, "_err"},      32'(err),      32'd0);
   endtask

   initial begin
      logic d_order [6];
      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
      step(); step();
      chk_reset_outputs("rst");
      RST = 1'b0;
      step();

      // I read, ACCESS immediately
      iREN = 1; iaddr = 32'h40; ramstate = ACC; ramload = 32'h8C220004;
      step();
      chk("t1_ramREN",  32'(ramREN), 32'd1);
      chk("t1_ramaddr", ramaddr,     32'h40);
      chk("t1_iwait_n1", 32'(iwait), 32'd1);
      step();
      chk("t1_iwait",  32'(iwait), 32'd0);
      chk("t1_iload",  iload,      32'h8C220004);
      chk("t1_dwait",  32'(dwait), 32'd1);
      chk("t1_ramREN_resp", 32'(ramREN), 32'd0);
      iREN = 0;
      step();
      chk("t1_iwait_after", 32'(iwait), 32'd1);
      chk("t1_iload_after", iload,      32'd0);

      // D write with 3 BUSY cycles then ACCESS
      dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
      step();
      chk("t2_ramWEN_c1",  32'(ramWEN), 32'd1);
      chk("t2_ramREN_c1",  32'(ramREN), 32'd0);
      chk("t2_ramaddr",    ramaddr,     32'h100);
      chk("t2_ramstore",   ramstore,    32'hDEADBEEF);
      step();
      chk("t2_ramWEN_c2",  32'(ramWEN), 32'd1);
      step();
      chk("t2_ramWEN_c3",  32'(ramWEN), 32'd1);
      step();
      chk("t2_ramWEN_c4",  32'(ramWEN), 32'd1);
      chk("t2_dwait_c4",   32'(dwait),  32'd1);
      ramstate = ACC;
      step();
      chk("t2_dwait",      32'(dwait),  32'd0);
      chk("t2_iwait",      32'(iwait),  32'd1);
      chk("t2_ramWEN_resp", 32'(ramWEN), 32'd0);
      dWEN = 0;
      step();

      // Both requesters held: grants D, D, I, D, D, I every 3 cycles
      d_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h200; ramload = 32'h11112222;
      for (int k = 1; k <= 18; k++) begin
         logic resp_cycle;
         logic exp_d, exp_i;
         step();
         resp_cycle = (k % 3 == 2);
         exp_d = resp_cycle && d_order[(k - 2) / 3];
         exp_i = resp_cycle && !d_order[(k - 2) / 3];
         chk($sformatf("t3_dwait_k%0d", k), 32'(dwait), 32'(!exp_d));
         chk($sformatf("t3_iwait_k%0d", k), 32'(iwait), 32'(!exp_i));
         if (k % 3 == 1)
            chk($sformatf("t3_ramaddr_k%0d", k), ramaddr,
                d_order[(k - 1) / 3] ? 32'h200 : 32'h300);
         if (exp_d) chk($sformatf("t3_dload_k%0d", k), dload, 32'h11112222);
         if (exp_i) chk($sformatf("t3_iload_k%0d", k), iload, 32'h11112222);
      end
      iREN = 0; dREN = 0;
      step();

      // Stuck BUSY with TIMEOUT=4: response N+6 with error word
      dREN = 1; daddr = 32'h50; ramstate = BUSY;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("t4_dwait_k%0d", k), 32'(dwait),  32'd1);
         chk($sformatf("t4_ramREN_k%0d", k), 32'(ramREN), 32'd1);
      end
      chk("t4_err_before", 32'(err), 32'd0);
      step();
      chk("t4_dwait", 32'(dwait), 32'd0);
      chk("t4_dload", dload,      32'hBAD1BAD1);
      chk("t4_err",   32'(err),   32'd1);
      dREN = 0;
      step();
      iREN = 1; iaddr = 32'h44; ramstate = ACC; ramload = 32'h12345678;
      step();
      step();
      chk("t4_good_iwait", 32'(iwait), 32'd0);
      chk("t4_good_iload", iload,      32'h12345678);
      chk("t4_err_sticky", 32'(err),   32'd1);
      iREN = 0;
      step();

      // Reset in the 2nd D_ACC cycle, then a held I read is served
      dREN = 1; daddr = 32'h70; iREN = 1; iaddr = 32'h80; ramstate = BUSY;
      step();
      step();
      chk("t6_ramREN_pre", 32'(ramREN), 32'd1);
      chk("t6_ramaddr_pre", ramaddr,    32'h70);
      RST = 1; dREN = 0;
      step();
      chk_reset_outputs("t6");
      RST = 0; ramstate = ACC; ramload = 32'hCAFEF00D;
      step();
      chk("t6_ramREN",  32'(ramREN), 32'd1);
      chk("t6_ramaddr", ramaddr,     32'h80);
      step();
      chk("t6_iwait", 32'(iwait), 32'd0);
      chk("t6_iload", iload,      32'hCAFEF00D);
      chk("t6_err",   32'(err),   32'd0);
      iREN = 0;
      step();

      // ERROR status on a D read
      dREN = 1; daddr = 32'h60; ramstate = ERR;
      step();
      chk("t5_ramREN", 32'(ramREN), 32'd1);
      step();
      chk("t5_dwait", 32'(dwait), 32'd0);
      chk("t5_dload", dload,      32'hBAD1BAD1);
      chk("t5_err",   32'(err),   32'd1);
      chk("t5_iwait", 32'(iwait), 32'd1);
      dREN = 0;
      step();
      chk("t5_dload_after", dload, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
